// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    localparam int          N_STEPS   = 16;
    localparam logic [3:0]  LAST_STEP = 4'(N_STEPS - 1);
    localparam logic [15:0] MIN_NEG   = 16'h8000;
    localparam logic [31:0] MIN_SQ    = 32'h4000_0000;

    // True for the one 16-bit value whose negation does not fit in 16 bits.
    function automatic logic is_min_neg(input logic [15:0] v);
        return (v == MIN_NEG);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand / product handshake bundle for booth_mult_seq.
interface booth_mult_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    // Producer/consumer side: supplies operands, accepts products.
    modport master (
        output in_valid,
        output multiplicand,
        output multiplier,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    // Multiplier side.
    modport slave (
        input  in_valid,
        input  multiplicand,
        input  multiplier,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );

endinterface

// File: rtl/booth_substep.sv
// One combinational radix-2 Booth step: recode {q[0], q0}, add/subtract m
// into the accumulator, then arithmetic-shift {acc, q, q0} right by one.
module booth_substep (
    input  logic [15:0] a,
    input  logic [15:0] q,
    input  logic [15:0] m,
    input  logic        q0,
    output logic [15:0] f16,
    output logic [15:0] l16,
    output logic        cq0
);

    logic [15:0] sum_s;

    // Booth recode and add/subtract, followed by the one-bit arithmetic shift.
    always_comb begin
        sum_s = a;
        case ({q[0], q0})
            2'b01:   sum_s = a + m;
            2'b10:   sum_s = a - m;
            default: sum_s = a;
        endcase
        f16 = {sum_s[15], sum_s[15:1]};
        l16 = {sum_s[0], q[15:1]};
        cq0 = q[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed 16x16 -> 32 Booth multiplier: one Booth step per clock
// for 16 clocks, product presented over a valid/ready handshake.
module booth_mult_seq
    import booth_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    booth_mult_seq_if.slave  bus
);

    booth_state_t state_r;
    logic [3:0]   cnt_r;
    logic [15:0]  a_r;
    logic [15:0]  q_r;
    logic [15:0]  m_r;
    logic         q1_r;
    logic         both_min_r;
    logic [31:0]  product_r;

    logic [15:0]  f16_s;
    logic [15:0]  l16_s;
    logic         cq0_s;
    logic         swap_s;

    booth_substep u_substep (
        .a   (a_r),
        .q   (q_r),
        .m   (m_r),
        .q0  (q1_r),
        .f16 (f16_s),
        .l16 (l16_s),
        .cq0 (cq0_s)
    );

    // A -32768 multiplicand would overflow the 16-bit accumulator, so it is
    // moved into the multiplier slot unless both operands are -32768.
    assign swap_s = is_min_neg(bus.multiplicand) && !is_min_neg(bus.multiplier);

    assign bus.in_ready  = (state_r == IDLE) && !rst;
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r == RUN) || (state_r == DONE);
    assign bus.product   = product_r;

    // Control FSM plus datapath registers: capture, 16 Booth steps, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            a_r        <= 16'd0;
            q_r        <= 16'd0;
            m_r        <= 16'd0;
            q1_r       <= 1'b0;
            both_min_r <= 1'b0;
            product_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= 16'd0;
                        q1_r       <= 1'b0;
                        cnt_r      <= 4'd0;
                        both_min_r <= is_min_neg(bus.multiplicand) &&
                                      is_min_neg(bus.multiplier);
                        if (swap_s) begin
                            m_r <= bus.multiplier;
                            q_r <= bus.multiplicand;
                        end else begin
                            m_r <= bus.multiplicand;
                            q_r <= bus.multiplier;
                        end
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= f16_s;
                    q_r   <= l16_s;
                    q1_r  <= cq0_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == LAST_STEP) begin
                        product_r <= both_min_r ? MIN_SQ : {f16_s, l16_s};
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
